// File: rtl/sc_xbar_pkg.sv
// Shared definitions for the crossbar slice: arbiter FSM encodings, bus widths,
// the timeout error pattern and a small index-wrap helper.
package sc_xbar_pkg;

  localparam int SC_DATA_W = 32;
  localparam int SC_ADDR_W = 32;

  localparam logic [SC_DATA_W-1:0] SC_TIMEOUT_PATTERN = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUSY  = 2'b01,
    ST_DRAIN = 2'b10
  } sc_arb_state_e;

  // Wraps an index that can exceed the range by less than one full lap.
  function automatic int sc_wrap(input int idx, input int n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

// File: rtl/sc_rr_pick.sv
// Round-robin winner search: ascends from the pointer with wrap, returning a
// one-hot winner and a valid flag.
module sc_rr_pick
  import sc_xbar_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int PTR_W     = 2
) (
  input  logic [N_MASTERS-1:0] i_req,
  input  logic [PTR_W-1:0]     i_ptr,
  output logic [N_MASTERS-1:0] o_gnt,
  output logic                 o_valid
);

  logic [N_MASTERS-1:0] w_gnt;
  logic                 w_found;

  // First requester at or after the pointer wins.
  always_comb begin
    w_gnt   = '0;
    w_found = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (!w_found && i_req[sc_wrap(int'(i_ptr) + i, N_MASTERS)]) begin
        w_gnt[sc_wrap(int'(i_ptr) + i, N_MASTERS)] = 1'b1;
        w_found = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

  assign o_gnt   = w_gnt;
  assign o_valid = w_found;

endmodule

// File: rtl/sc_rr_arbiter.sv
// Round-robin arbiter sharing one slave port among N_MASTERS masters.
// Optional slave-ack timeout is enabled by defining SC_ARB_TIMEOUT_EN.
module sc_rr_arbiter
  import sc_xbar_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                           i_clk,
  input  logic                           i_resetb,
  input  logic [N_MASTERS-1:0]           i_m_req,
  input  logic [SC_ADDR_W*N_MASTERS-1:0] i_m_addr,
  input  logic [N_MASTERS-1:0]           i_m_cmd,
  input  logic [SC_DATA_W*N_MASTERS-1:0] i_m_wdata,
  output logic [N_MASTERS-1:0]           o_m_ack,
  output logic [N_MASTERS-1:0]           o_m_err,
  output logic [SC_DATA_W-1:0]           o_m_rdata,
  output logic                           o_s_req,
  output logic [SC_ADDR_W-1:0]           o_s_addr,
  output logic                           o_s_cmd,
  output logic [SC_DATA_W-1:0]           o_s_wdata,
  input  logic                           i_s_ack,
  input  logic [SC_DATA_W-1:0]           i_s_rdata,
  output logic [N_MASTERS-1:0]           o_grant
);

  localparam int PW = $clog2(N_MASTERS);

  sc_arb_state_e r_state, w_state_nxt;

  logic [PW-1:0]        r_ptr, w_ptr_nxt, w_ptr_adv, w_gidx;
  logic [N_MASTERS-1:0] w_pick_gnt;
  logic                 w_pick_vld;
  logic [SC_ADDR_W-1:0] w_sel_addr;
  logic [SC_DATA_W-1:0] w_sel_wdata;
  logic                 w_sel_cmd;
  logic                 w_timeout;

  logic                 r_s_req,   w_s_req_nxt;
  logic [SC_ADDR_W-1:0] r_s_addr,  w_s_addr_nxt;
  logic                 r_s_cmd,   w_s_cmd_nxt;
  logic [SC_DATA_W-1:0] r_s_wdata, w_s_wdata_nxt;
  logic [N_MASTERS-1:0] r_m_ack,   w_m_ack_nxt;
  logic [SC_DATA_W-1:0] r_m_rdata, w_m_rdata_nxt;
  logic [N_MASTERS-1:0] r_grant,   w_grant_nxt;

  sc_rr_pick #(
    .N_MASTERS(N_MASTERS),
    .PTR_W    (PW)
  ) u_pick (
    .i_req  (i_m_req),
    .i_ptr  (r_ptr),
    .o_gnt  (w_pick_gnt),
    .o_valid(w_pick_vld)
  );

  // One-hot AND-OR mux of the winning master's request fields.
  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_cmd   = 1'b0;
    w_gidx      = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      w_sel_addr  = w_sel_addr  | ({SC_ADDR_W{w_pick_gnt[k]}} & i_m_addr[k*SC_ADDR_W +: SC_ADDR_W]);
      w_sel_wdata = w_sel_wdata | ({SC_DATA_W{w_pick_gnt[k]}} & i_m_wdata[k*SC_DATA_W +: SC_DATA_W]);
      w_sel_cmd   = w_sel_cmd   | (w_pick_gnt[k] & i_m_cmd[k]);
      w_gidx      = w_gidx      | ({PW{w_pick_gnt[k]}} & PW'(k));
    end
  end

  assign w_ptr_adv = (w_gidx == PW'(N_MASTERS - 1)) ? '0 : (w_gidx + 1'b1);

  // State register.
  always_ff @(posedge i_clk or negedge i_resetb) begin
    if (!i_resetb) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) w_state_nxt = ST_BUSY;
        else            w_state_nxt = ST_IDLE;
      end
      ST_BUSY: begin
        if (i_s_ack || w_timeout) w_state_nxt = ST_DRAIN;
        else                      w_state_nxt = ST_BUSY;
      end
      ST_DRAIN: begin
        if (!i_s_ack) w_state_nxt = ST_IDLE;
        else          w_state_nxt = ST_DRAIN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; o_m_ack defaults low so it pulses once.
  always_comb begin
    w_s_req_nxt   = r_s_req;
    w_s_addr_nxt  = r_s_addr;
    w_s_cmd_nxt   = r_s_cmd;
    w_s_wdata_nxt = r_s_wdata;
    w_m_ack_nxt   = '0;
    w_m_rdata_nxt = r_m_rdata;
    w_grant_nxt   = r_grant;
    w_ptr_nxt     = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) begin
          w_s_req_nxt   = 1'b1;
          w_s_addr_nxt  = w_sel_addr;
          w_s_cmd_nxt   = w_sel_cmd;
          w_s_wdata_nxt = w_sel_wdata;
          w_grant_nxt   = w_pick_gnt;
          w_ptr_nxt     = w_ptr_adv;
        end else begin
          w_s_req_nxt = 1'b0;
          w_grant_nxt = '0;
        end
      end
      ST_BUSY: begin
        if (i_s_ack) begin
          w_s_req_nxt = 1'b0;
          w_m_ack_nxt = r_grant;
          if (!r_s_cmd) w_m_rdata_nxt = i_s_rdata;
          else          w_m_rdata_nxt = r_m_rdata;
        end else if (w_timeout) begin
          w_s_req_nxt   = 1'b0;
          w_m_ack_nxt   = r_grant;
          w_m_rdata_nxt = SC_TIMEOUT_PATTERN;
        end else begin
          w_s_req_nxt = 1'b1;
        end
      end
      ST_DRAIN: begin
        w_s_req_nxt = 1'b0;
        if (!i_s_ack) w_grant_nxt = '0;
        else          w_grant_nxt = r_grant;
      end
      default: begin
        w_s_req_nxt = 1'b0;
        w_grant_nxt = '0;
      end
    endcase
  end

  // Output and pointer registers.
  always_ff @(posedge i_clk or negedge i_resetb) begin
    if (!i_resetb) begin
      r_s_req   <= 1'b0;
      r_s_addr  <= '0;
      r_s_cmd   <= 1'b0;
      r_s_wdata <= '0;
      r_m_ack   <= '0;
      r_m_rdata <= '0;
      r_grant   <= '0;
      r_ptr     <= '0;
    end else begin
      r_s_req   <= w_s_req_nxt;
      r_s_addr  <= w_s_addr_nxt;
      r_s_cmd   <= w_s_cmd_nxt;
      r_s_wdata <= w_s_wdata_nxt;
      r_m_ack   <= w_m_ack_nxt;
      r_m_rdata <= w_m_rdata_nxt;
      r_grant   <= w_grant_nxt;
      r_ptr     <= w_ptr_nxt;
    end
  end

`ifdef SC_ARB_TIMEOUT_EN
  localparam int CW_RAW = $clog2(TIMEOUT + 1);
  localparam int CW     = (CW_RAW > 8) ? CW_RAW : 8;

  logic [CW-1:0]        r_tmo_cnt;
  logic [N_MASTERS-1:0] r_m_err;

  // Counter is held at zero outside a transaction, so it starts from zero on BUSY entry.
  always_ff @(posedge i_clk or negedge i_resetb) begin
    if (!i_resetb) begin
      r_tmo_cnt <= '0;
    end else if (r_state == ST_BUSY) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  assign w_timeout = (r_state == ST_BUSY) && !i_s_ack && (r_tmo_cnt == CW'(TIMEOUT - 1));

  // Error flag pulses alongside the timeout ack.
  always_ff @(posedge i_clk or negedge i_resetb) begin
    if (!i_resetb) begin
      r_m_err <= '0;
    end else if (w_timeout) begin
      r_m_err <= r_grant;
    end else begin
      r_m_err <= '0;
    end
  end

  assign o_m_err = r_m_err;
`else
  assign w_timeout = 1'b0;
  assign o_m_err   = '0;
`endif

  assign o_m_ack   = r_m_ack;
  assign o_m_rdata = r_m_rdata;
  assign o_s_req   = r_s_req;
  assign o_s_addr  = r_s_addr;
  assign o_s_cmd   = r_s_cmd;
  assign o_s_wdata = r_s_wdata;
  assign o_grant   = r_grant;

endmodule

// File: doc/sc_rr_arbiter.md
SC_RR_ARBITER -- requirements
Module: sc_rr_arbiter

Interface
REQ-001 SHALL have parameter N_MASTERS, default 4, number of requesting masters (2..16).
REQ-002 SHALL have parameter TIMEOUT, default 255, max slave-ack wait in cycles (used only with SC_ARB_TIMEOUT_EN).
REQ-003 SHALL have ports, clock and reset first:
- i_clk  in  1  clock.
- i_resetb  in  1  reset, asynchronous, active-low.
- i_m_req  in  N_MASTERS  per-master request.
- i_m_addr  in  32*N_MASTERS  per-master address, master k at bits [32k+31:32k].
- i_m_cmd  in  N_MASTERS  per-master command, 1=write, 0=read.
- i_m_wdata  in  32*N_MASTERS  per-master write data, same packing.
- o_m_ack  out  N_MASTERS  per-master one-cycle completion pulse.
- o_m_err  out  N_MASTERS  per-master timeout flag, valid with o_m_ack.
- o_m_rdata  out  32  read data, shared, valid with any o_m_ack bit.
- o_s_req  out  1  slave request.
- o_s_addr  out  32  slave address.
- o_s_cmd  out  1  slave command.
- o_s_wdata  out  32  slave write data.
- i_s_ack  in  1  slave ack, level; high while slave holds request, falls one cycle after o_s_req falls.
- i_s_rdata  in  32  slave read data.
- o_grant  out  N_MASTERS  one-hot current owner, 0 when idle.

Function
REQ-004 SHALL implement FSM IDLE, BUSY, DRAIN; all outputs registered.
REQ-005 IDLE: if any i_m_req high at a clock edge, SHALL select winner g by round-robin, latch its addr/cmd/wdata onto o_s_*, set o_s_req=1, o_grant=1<<g, go BUSY; else stay IDLE.
REQ-006 Round-robin: search starts at pointer p and ascends with wrap N_MASTERS-1 -> 0; on grant p SHALL become (g+1) mod N_MASTERS.
REQ-007 BUSY: o_s_* SHALL stay constant; master inputs are ignored, including i_m_req changes by the owner.
REQ-008 BUSY with i_s_ack=1: SHALL set o_s_req=0, o_m_rdata=i_s_rdata (reads; unchanged on writes), pulse o_m_ack[g] for exactly one cycle, go DRAIN.
REQ-009 DRAIN: SHALL hold o_s_req=0 and o_grant, return to IDLE on first edge with i_s_ack=0, clearing o_grant.
REQ-010 Masters SHALL drop i_m_req within one cycle after o_m_ack; a request still high on IDLE entry counts as new.
REQ-011 Minimum transaction: grant edge to o_m_ack high 2 cycles with the standard slave; IDLE re-entry 2 cycles after o_m_ack.
REQ-012 Simultaneous requests SHALL resolve in one edge; requests arriving in BUSY/DRAIN wait, never lost while held.
REQ-013 i_s_ack high in IDLE SHALL be ignored.

Reset
REQ-014 On i_resetb low, asynchronously: state=IDLE, p=0, o_s_req=0, o_s_addr=0, o_s_cmd=0, o_s_wdata=0, o_m_ack=0, o_m_err=0, o_m_rdata=0, o_grant=0.
REQ-015 Reset mid-transaction SHALL abort without o_m_ack; after release, normal arbitration from p=0.

Configuration
REQ-016 Macro SC_ARB_TIMEOUT_EN defined: 8-bit-or-wider counter clears on BUSY entry, increments each BUSY cycle; reaching TIMEOUT with i_s_ack=0 SHALL drop o_s_req, pulse o_m_ack[g] and o_m_err[g], set o_m_rdata=32'hDEADBEEF, go DRAIN.
REQ-017 Macro undefined: no counter, BUSY waits indefinitely, o_m_err tied 0; port list unchanged.

Structure
REQ-018 Package sc_xbar_pkg SHALL hold FSM state encodings, data/address width 32, timeout error pattern 32'hDEADBEEF.
REQ-019 Combinational sub-module sc_rr_pick (request vector, pointer -> one-hot winner, valid) SHALL perform REQ-006 search.

Verification
REQ-020 Single master 0 write addr 0x10 data 0xA5A5A5A5 -> o_s_req 1 cycle after req, o_m_ack[0] one pulse, o_m_err[0]=0, then read 0x10 returns 0xA5A5A5A5.
REQ-021 All 4 masters request from reset, held -> grant order 0,1,2,3,0; each o_m_ack a single pulse.
REQ-022 Masters 1 and 3 request, p=2 -> master 3 granted first, then 1; p ends at 2.
REQ-023 Master 2 raises req while master 0 in BUSY -> master 2 granted on first IDLE edge after DRAIN, o_s_addr unchanged during master 0 BUSY.
REQ-024 Reset pulse during BUSY -> all outputs 0 within the reset cycle, no o_m_ack, next grant starts from master 0.
REQ-025 With SC_ARB_TIMEOUT_EN, TIMEOUT=8, slave never acks -> after 8 BUSY cycles o_m_ack[g]=o_m_err[g]=1, o_m_rdata=0xDEADBEEF, FSM back in IDLE.
